ti_adc_capture_ctrl: RTL

- Capture sequencer for the time-interleaved SAR-ADC output.
- Runs on the ADC core clock and receives one frame per valid cycle. A frame holds ADC_WAYS sub-ADC words, already aligned in the core domain.
- On arm plus trigger, stores a programmed number of frames into an internal flop buffer.
- Drains the buffer in time order (way 0..ADC_WAYS-1, then the next frame) over a valid/ready stream to the digital backend/scan readout.

---
 rtl/ti_adc_pkg.sv | 20 ++
 rtl/ti_adc_frame_buf.sv | 33 +++
 rtl/ti_adc_capture_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ti_adc_pkg.sv
// Shared types and constants for the time-interleaved ADC capture sequencer.
package ti_adc_pkg;

    localparam int unsigned ADC_BITS_DEF = 9;
    localparam int unsigned ADC_WAYS_DEF = 8;
    localparam int unsigned DEPTH_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_e;

    // Frame counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ti_adc_frame_buf.sv
// Capture buffer: DEPTH frames of ADC_WAYS words, one-frame write port,
// combinational single-word read port.
module ti_adc_frame_buf #(
    parameter int unsigned ADC_BITS = 9,
    parameter int unsigned ADC_WAYS = 8,
    parameter int unsigned DEPTH    = 16,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned WAY_W   = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [ADC_WAYS*ADC_BITS-1:0] wr_frame,
    input  logic [ADDR_W-1:0]            rd_frame,
    input  logic [WAY_W-1:0]             rd_way,
    output logic [ADC_BITS-1:0]          rd_word
);

    logic [ADC_WAYS-1:0][ADC_BITS-1:0] mem_q [DEPTH];

    // Store a whole frame; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_frame;
        end
    end

    // Zero-latency word select for the readout stream.
    always_comb begin
        rd_word = mem_q[rd_frame][rd_way];
    end

endmodule

// File: rtl/ti_adc_capture_ctrl.sv
// Capture sequencer for the time-interleaved SAR-ADC: arm, trigger, store
// a programmed number of frames, then drain them word by word in time order.
// Optional level trigger enabled by defining TI_ADC_CAPTURE_TRIG_LEVEL_EN.
module ti_adc_capture_ctrl
    import ti_adc_pkg::*;
#(
    parameter int unsigned ADC_BITS = ADC_BITS_DEF,
    parameter int unsigned ADC_WAYS = ADC_WAYS_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    localparam int unsigned CNT_W   = cnt_width(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_valid,
    input  logic [ADC_WAYS*ADC_BITS-1:0] frame_data,
    input  logic                         arm,
    input  logic                         sw_trig,
    input  logic                         abort,
    input  logic [CNT_W-1:0]             cfg_frames,
`ifdef TI_ADC_CAPTURE_TRIG_LEVEL_EN
    input  logic [ADC_BITS-1:0]          cfg_trig_level,
`endif
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [ADC_BITS-1:0]          rd_data,
    output logic                         rd_last,
    output logic                         done,
    output logic [1:0]                   state_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned WAY_W  = (ADC_WAYS > 1) ? $clog2(ADC_WAYS) : 1;
    localparam logic [WAY_W-1:0] WAY_LAST  = WAY_W'(ADC_WAYS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   rd_frame_q, rd_frame_d;
    logic [WAY_W-1:0]    rd_way_q, rd_way_d;
    logic                pend_q, pend_d;
    logic                done_q, done_d;

    logic                level_hit;
    logic                trig;
    logic [CNT_W-1:0]    cfg_clamped;
    logic                buf_we;
    logic [ADDR_W-1:0]   buf_waddr;
    logic [ADC_BITS-1:0] buf_word;
    logic                last_word;

`ifdef TI_ADC_CAPTURE_TRIG_LEVEL_EN
    // Level trigger: any way word at or above the programmed threshold.
    always_comb begin
        level_hit = 1'b0;
        for (int unsigned i = 0; i < ADC_WAYS; i++) begin
            if (frame_data[i*ADC_BITS +: ADC_BITS] >= cfg_trig_level) begin
                level_hit = 1'b1;
            end
        end
    end
`else
    // Level trigger absent: only the software trigger starts a capture.
    always_comb begin
        level_hit = 1'b0;
    end
`endif

    // Trigger qualification, length clamp and readout status.
    always_comb begin
        trig        = sw_trig | (frame_valid & level_hit);
        cfg_clamped = ((cfg_frames == '0) || (cfg_frames > DEPTH_CNT)) ? DEPTH_CNT : cfg_frames;
        rd_valid    = (state_q == ST_READOUT);
        last_word   = rd_valid && ({1'b0, rd_frame_q} == (n_q - CNT_W'(1)))
                      && (rd_way_q == WAY_LAST);
        rd_last     = last_word;
        rd_data     = rd_valid ? buf_word : '0;
        done        = done_q;
        state_o     = state_q;
    end

    // Sequencer next state, counters and buffer write control.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wr_cnt_d   = wr_cnt_q;
        rd_frame_d = rd_frame_q;
        rd_way_d   = rd_way_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        buf_we     = 1'b0;
        buf_waddr  = wr_cnt_q[ADDR_W-1:0];

        case (state_q)
            ST_IDLE: begin
                wr_cnt_d   = '0;
                rd_frame_d = '0;
                rd_way_d   = '0;
                pend_d     = 1'b0;
                if (arm) begin
                    n_d     = cfg_clamped;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // A trigger seen without data stays pending until the next frame.
                if (frame_valid && (trig || pend_q)) begin
                    buf_we    = 1'b1;
                    buf_waddr = '0;
                    wr_cnt_d  = CNT_W'(1);
                    pend_d    = 1'b0;
                    state_d   = (n_q == CNT_W'(1)) ? ST_READOUT : ST_CAPTURE;
                end else if (trig) begin
                    pend_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (frame_valid) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if ((wr_cnt_q + CNT_W'(1)) == n_q) begin
                        state_d = ST_READOUT;
                    end
                end
            end
            ST_READOUT: begin
                if (rd_ready) begin
                    if (last_word) begin
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                        wr_cnt_d   = '0;
                        rd_frame_d = '0;
                        rd_way_d   = '0;
                    end else if (rd_way_q == WAY_LAST) begin
                        rd_way_d   = '0;
                        rd_frame_d = rd_frame_q + ADDR_W'(1);
                    end else begin
                        rd_way_d = rd_way_q + WAY_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides arm, trigger and the final handshake alike.
        if (abort) begin
            state_d    = ST_IDLE;
            n_d        = '0;
            wr_cnt_d   = '0;
            rd_frame_d = '0;
            rd_way_d   = '0;
            pend_d     = 1'b0;
            done_d     = 1'b0;
            buf_we     = 1'b0;
        end
    end

    // Sequencer state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            wr_cnt_q   <= '0;
            rd_frame_q <= '0;
            rd_way_q   <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_frame_q <= rd_frame_d;
            rd_way_q   <= rd_way_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
        end
    end

    ti_adc_frame_buf #(
        .ADC_BITS (ADC_BITS),
        .ADC_WAYS (ADC_WAYS),
        .DEPTH    (DEPTH)
    ) u_frame_buf (
        .clk      (clk),
        .wr_en    (buf_we),
        .wr_addr  (buf_waddr),
        .wr_frame (frame_data),
        .rd_frame (rd_frame_q),
        .rd_way   (rd_way_q),
        .rd_word  (buf_word)
    );

endmodule
